serial_and_driver: RTL and testbench

SERIAL_AND_DRIVER -- requirements
Module: serial_and_driver

---
 rtl/serial_and_pkg.sv | 25 ++
 rtl/nand_and.sv | 20 ++
 rtl/serial_and_driver.sv | 165 ++++++++++++++++
 tb/tb_serial_and_driver.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_and_pkg.sv
// -----------------------------------------------------------------------------
// serial_and_pkg
// Shared definitions for the bit-serial AND driver:
//   - state_t      : FSM state encoding (IDLE / SHIFT / DONE)
//   - WIDTH_MIN/MAX: legal range of the operand width parameter
//   - parity32     : even-parity helper (XOR of all bits), used only when the
//                    optional parity output is built (SERIAL_AND_PARITY_EN)
// -----------------------------------------------------------------------------
package serial_and_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

    // XOR of all bits; narrower vectors are zero-extended by the caller.
    function automatic logic parity32(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/nand_and.sv
// -----------------------------------------------------------------------------
// nand_and
// Two-NAND AND cell: y = a AND b, built as NAND(a,b) followed by a NAND used
// as an inverter.
// Ports:
//   a, b : inputs
//   y    : a AND b
// -----------------------------------------------------------------------------
module nand_and (
    input  logic a,
    input  logic b,
    output logic y
);

    logic nand1_s;

    assign nand1_s = ~(a & b);
    assign y       = ~(nand1_s & nand1_s);

endmodule

// File: rtl/serial_and_driver.sv
// -----------------------------------------------------------------------------
// serial_and_driver
// Bit-serial bitwise AND of two WIDTH-bit operands. An accepted operand pair is
// loaded into two shift registers; every SHIFT cycle the two LSBs pass through
// one nand_and cell and the cell output is shifted into the result MSB. After
// WIDTH SHIFT cycles the result is presented in DONE until the consumer takes it.
//
// Parameters:
//   WIDTH     : operand/result width, 1..32
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : operand pair offered (ignored outside IDLE)
//   in_ready  : 1 in IDLE only
//   in_a,in_b : operands
//   out_valid : 1 in DONE only
//   out_ready : consumer takes the result (leaves DONE)
//   out_data  : result register (in_a AND in_b once DONE)
//   out_par   : XOR of out_data bits; only when SERIAL_AND_PARITY_EN is defined
// -----------------------------------------------------------------------------
module serial_and_driver
    import serial_and_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SERIAL_AND_PARITY_EN
    output logic             out_par,
`endif
    output logic [WIDTH-1:0] out_data
);

    // Counter is one bit wider than needed for WIDTH-1 so it can never wrap.
    localparam int                CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   res_r;
    logic               bit_s;
    logic [WIDTH-1:0]   bit_msb_s;

    nand_and u_and (
        .a (a_r[0]),
        .b (b_r[0]),
        .y (bit_s)
    );

    // Place the cell output at the MSB position (works for WIDTH=1 as well).
    always_comb begin
        bit_msb_s            = '0;
        bit_msb_s[WIDTH-1]   = bit_s;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == LAST_BIT) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE: begin
                // Returning to IDLE here means in_valid is not looked at on this edge.
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM output decode (state_r is a register, so these are glitch-free).
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            IDLE:    in_ready  = 1'b1;
            SHIFT:   in_ready  = 1'b0;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Operand shift registers, result register and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            a_r   <= '0;
            b_r   <= '0;
            res_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        cnt_r <= '0;
                        a_r   <= in_a;
                        b_r   <= in_b;
                        res_r <= '0;
                    end
                end
                SHIFT: begin
                    cnt_r <= cnt_r + 1'b1;
                    a_r   <= a_r >> 1'b1;
                    b_r   <= b_r >> 1'b1;
                    res_r <= (res_r >> 1'b1) | bit_msb_s;
                end
                DONE: begin
                    // Result held until consumed.
                    res_r <= res_r;
                end
                default: begin
                    cnt_r <= '0;
                    a_r   <= '0;
                    b_r   <= '0;
                    res_r <= '0;
                end
            endcase
        end
    end

    assign out_data = res_r;

`ifdef SERIAL_AND_PARITY_EN
    // res_r is 0 in reset, so parity is 0 there as well.
    assign out_par = parity32(32'(res_r));
`endif

endmodule

// File: tb/tb_serial_and_driver.sv
// -----------------------------------------------------------------------------
// tb_serial_and_driver
// Scoreboard bench: a WIDTH=8 instance driven with directed and random operand
// pairs (expected result pushed on accept, popped by a monitor when out_valid
// rises), plus a WIDTH=1 instance checked directly.
// -----------------------------------------------------------------------------
module tb_serial_and_driver;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    logic         in_valid1;
    logic         in_ready1;
    logic [0:0]   in_a1;
    logic [0:0]   in_b1;
    logic         out_valid1;
    logic         out_ready1;
    logic [0:0]   out_data1;

`ifdef SERIAL_AND_PARITY_EN
    logic         out_par;
    logic         out_par1;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] data;
        int           acc;
    } exp_t;

    exp_t exp_q[$];

    serial_and_driver #(.WIDTH(W)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SERIAL_AND_PARITY_EN
        .out_par   (out_par),
`endif
        .out_data  (out_data)
    );

    serial_and_driver #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_a      (in_a1),
        .in_b      (in_b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
`ifdef SERIAL_AND_PARITY_EN
        .out_par   (out_par1),
`endif
        .out_data  (out_data1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain bitwise AND and population-count parity.
    function automatic logic [W-1:0] model_and(input logic [W-1:0] a, input logic [W-1:0] b);
        return a & b;
    endfunction

    function automatic logic model_par(input logic [W-1:0] d);
        return logic'($countones(d) % 2);
    endfunction

    // Monitor: pops on the rising edge of out_valid, then checks the result is held.
    initial begin
        bit           prev_v = 1'b0;
        logic [W-1:0] held   = '0;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid && !prev_v) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_data", 32'(out_data), 32'(e.data));
                        check("result_latency", 32'(cyc - e.acc), 32'(W));
                        check("result_in_ready", 32'(in_ready), 32'd0);
`ifdef SERIAL_AND_PARITY_EN
                        check("result_parity", 32'(out_par), 32'(model_par(e.data)));
`endif
                    end
                    held = out_data;
                end else if (out_valid && prev_v) begin
                    check("hold_data", 32'(out_data), 32'(held));
                    check("hold_in_ready", 32'(in_ready), 32'd0);
                end
            end
            prev_v = out_valid;
        end
    end

    // One operation on the WIDTH=8 instance: accept, optional ignored re-offer
    // during SHIFT, wait for the result, hold it for 'hold' cycles, release.
    task automatic op8(input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input bit poke);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        out_ready = 1'b0;
        e.data    = model_and(a, b);
        e.acc     = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        if (poke) begin
            in_a = '0;
            in_b = '0;
            repeat (3) @(negedge clk);
        end
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        n = 0;
        while (!out_valid && n < 3 * W) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("done_timeout", 32'd0, 32'd1);
        repeat (hold) @(negedge clk);
        // Offer junk on the releasing edge; it must not be taken.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        in_a1      = '0;
        in_b1      = '0;
        out_ready1 = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_w1_in_ready", 32'(in_ready1), 32'd1);
        check("reset_w1_out_valid", 32'(out_valid1), 32'd0);
`ifdef SERIAL_AND_PARITY_EN
        check("reset_out_par", 32'(out_par), 32'd0);
`endif
        rst_n = 1'b1;

        // Directed cases.
        op8(8'hFF, 8'h0F, 0, 1'b0);
        op8(8'hA5, 8'h3C, 5, 1'b0);
        op8(8'hC3, 8'h7E, 1, 1'b1);
        op8(8'h07, 8'h03, 0, 1'b0);
        op8(8'h00, 8'hFF, 0, 1'b0);
        op8(8'hFF, 8'hFF, 2, 1'b0);

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 8'h12;
        in_b     = 8'h34;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_reset_out_valid", 32'(out_valid), 32'd0);
        check("midop_reset_out_data", 32'(out_data), 32'd0);
        check("midop_reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        op8(8'h55, 8'hFF, 0, 1'b0);

        // Random operations.
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            op8(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // WIDTH=1 instance: result after accept edge plus one SHIFT edge.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid1  = 1'b1;
            in_a1      = 1'(k);
            in_b1      = 1'(k >> 1);
            out_ready1 = 1'b1;
            @(negedge clk);
            in_valid1 = 1'b0;
            check("w1_shift_out_valid", 32'(out_valid1), 32'd0);
            @(negedge clk);
            check("w1_done_out_valid", 32'(out_valid1), 32'd1);
            check("w1_done_out_data", 32'(out_data1), 32'(in_a1 & in_b1));
            @(negedge clk);
            check("w1_idle_in_ready", 32'(in_ready1), 32'd1);
        end
        out_ready1 = 1'b0;

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
